mmio_stream: RTL and testbench
==============================

# mmio_stream

Buffered memory-mapped I/O decoder for the subleq core. It sits between the CPU datapath and main memory and intercepts accesses to the top words of the address space. Those accesses are routed to a parametrised input FIFO, an output FIFO, a status register and a sticky halt latch. Empty or full FIFOs back-pressure the CPU through a stall line instead of losing data.

## Interface
Parameters:
- `WIDTH`, default 16: word and address width.
- `IN_DEPTH`, default 4: input FIFO depth in words; power of two, ≥2.
- `OUT_DEPTH`, default 4: output FIFO depth in words; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `access` in 1: CPU performs a memory access this cycle.
- `load` in 1: 1 = read, 0 = write.
- `addr` in WIDTH: CPU address.
- `data_out` in WIDTH: CPU write data.
- `data_in` out WIDTH: read data to CPU.
- `stall` out 1: CPU must hold `access`/`addr`/`data_out` and retry next cycle.
- `halt` out 1: sticky halt.
- `mem_out` in WIDTH: memory read data.
- `mem_in` out WIDTH: memory write data.
- `mem_we` out 1: memory write enable.
- `addr_out` out WIDTH: address to memory, equal to `addr`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in WIDTH: input stream.
- `in_eof` in 1: end-of-input indication (level).
- `out_valid` out 1, `out_ready` in 1, `out_data` out WIDTH: output stream.

## Operation
- Address map, with M = 2^WIDTH:
  - M-1: halt.
  - M-2: input read.
  - M-3: output write.
  - M-4: status, only with `STATUS_REG_EN`.
  - All other addresses are memory.
- Memory addresses: `data_in`=`mem_out`; `mem_we`=`access & !load & !halt`; `mem_in`=`data_out`.
- I/O addresses: `mem_we`=0 and `mem_in`=0.
- Any access to M-1 sets `halt`.
- Read of M-2, FIFO non-empty: `data_in` = head word (first-word fall-through), pop at the clock edge.
- Read of M-2, FIFO empty, `eof_seen`=0: `stall`=1, no pop.
- Read of M-2, FIFO empty, `eof_seen`=1: set `halt`, `data_in`=0, no stall.
- Write to M-3, FIFO not full: push `data_out`.
- Write to M-3, FIFO full: `stall`=1, no push.
- Wrong-direction I/O accesses: write to M-2, read of M-3, write to M-4.
  - Ignored; reads return 0.
  - No FIFO change, no stall.
- Status word: bit0 = input non-empty, bit1 = output not full, bit2 = `eof_seen`, upper bits 0.
- `eof_seen` sets when `in_eof`=1 and stays set until reset.
- Input FIFO push on `in_valid & in_ready`; `in_ready` = `rst_n & !in_full`.
- Output FIFO: `out_valid` = !empty; `out_data` = head; pop on `out_valid & out_ready`.
- Once `halt`=1:
  - All CPU accesses are ignored: no pushes, pops or memory writes; `stall`=0.
  - Stream-side FIFO traffic continues so output drains.
- Occupancy counters are log2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.

## Timing
- `data_in`, `stall`, `mem_we`, `mem_in`, `addr_out` are combinational from inputs and registered state.
- No combinational path from `out_ready` or `in_valid` to `stall`.
  - A full output FIFO stalls the CPU even if it pops in the same cycle.
  - An empty input FIFO stalls the CPU even if a push arrives in the same cycle.
- Input word pushed at edge N is readable by the CPU in cycle N+1 (one-cycle latency).
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
- `halt` asserts in the cycle after the triggering access edge and holds until reset.
- Reset values, asynchronous and immediate:
  - FIFOs empty; `halt`=0; `eof_seen`=0.
  - `out_valid`=0, `in_ready`=0 while `rst_n`=0.
  - `stall`=0; `data_in` follows decode.
- Reset mid-operation discards all buffered words.

## Configuration
- `MMIO_STATUS_REG_EN` defined: M-4 decodes to the status register; I/O region is addr ≥ M-4.
- Undefined: M-4 is ordinary memory; I/O region is addr ≥ M-3; no status logic is synthesised.

## Test plan
- Push 0x0011, 0x0022 on input stream. CPU reads M-2 twice → `data_in` 0x0011 then 0x0022, `stall`=0 both cycles, FIFO empty afterwards.
- CPU reads M-2 with FIFO empty and `in_eof`=0 → `stall`=1. Push 0x00AB → next cycle `stall`=0, `data_in`=0x00AB.
- With WIDTH=16, OUT_DEPTH=4, `out_ready`=0: write 0x1,0x2,0x3,0x4, then 0x5 → fifth write stalls. Raise `out_ready` → out_data order is 1,2,3,4, then 5 accepted.
- Assert `in_eof` with input FIFO holding 0x0007. Read M-2 → 0x0007. Second read → `data_in`=0, `halt`=1 next cycle, later memory writes see `mem_we`=0.
- With `MMIO_STATUS_REG_EN`: empty input, `eof_seen`=0, empty output. Read 0xFFFC → 0x0002. Without the macro, a write to 0xFFFC asserts `mem_we`.
- Drop `rst_n` mid-burst with 3 words in each FIFO → immediately `out_valid`=0, `in_ready`=0, `halt`=0. After release, reading M-2 stalls.

Source files
------------

// File: rtl/mmio_stream_if.sv
// CPU-side memory bus plus the input/output word streams of the mmio_stream decoder.
interface mmio_stream_if #(
  parameter int WIDTH = 16
);
  logic             access;
  logic             load;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_in;
  logic             stall;
  logic             halt;
  logic [WIDTH-1:0] mem_out;
  logic [WIDTH-1:0] mem_in;
  logic             mem_we;
  logic [WIDTH-1:0] addr_out;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_eof;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  access, load, addr, data_out, mem_out, in_valid, in_data, in_eof, out_ready,
    output data_in, stall, halt, mem_in, mem_we, addr_out, in_ready, out_valid, out_data
  );

  modport master (
    output access, load, addr, data_out, mem_out, in_valid, in_data, in_eof, out_ready,
    input  data_in, stall, halt, mem_in, mem_we, addr_out, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mmio_stream.sv
// Memory-mapped I/O decoder for the subleq core: halt latch, input/output FIFOs and
// (when MMIO_STATUS_REG_EN is defined) a status word at the fourth-from-top address.
module mmio_stream #(
  parameter int WIDTH     = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mmio_stream_if.slave bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [WIDTH-1:0] A_HALT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] A_IN   = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] A_OUT  = {{(WIDTH-2){1'b1}}, 2'b01};

  logic [WIDTH-1:0] in_mem  [IN_DEPTH];
  logic [WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [IAW-1:0]   in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IAW:0]     in_cnt_q, in_cnt_d;
  logic [OAW-1:0]   out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OAW:0]     out_cnt_q, out_cnt_d;
  logic             halt_q, halt_d, eof_q, eof_d;

  logic in_empty, in_full, out_empty, out_full;
  logic hit_halt, hit_in, hit_out, hit_io;
  logic cpu_ok, rd, wr;
  logic in_push, in_pop, out_push, out_pop, halt_set;

  assign hit_halt = (bus.addr == A_HALT);
  assign hit_in   = (bus.addr == A_IN);
  assign hit_out  = (bus.addr == A_OUT);
`ifdef MMIO_STATUS_REG_EN
  localparam logic [WIDTH-1:0] A_STAT = {{(WIDTH-2){1'b1}}, 2'b00};
  logic             hit_stat;
  logic [WIDTH-1:0] status_word;
  assign hit_stat    = (bus.addr == A_STAT);
  assign hit_io      = hit_halt | hit_in | hit_out | hit_stat;
  assign status_word = {{(WIDTH-3){1'b0}}, eof_q, ~out_full, ~in_empty};
`else
  assign hit_io = hit_halt | hit_in | hit_out;
`endif

  assign in_empty  = (in_cnt_q == '0);
  assign in_full   = (in_cnt_q == (IAW+1)'(IN_DEPTH));
  assign out_empty = (out_cnt_q == '0);
  assign out_full  = (out_cnt_q == (OAW+1)'(OUT_DEPTH));

  // Once halted the CPU side is frozen; stream-side traffic keeps running.
  assign cpu_ok   = bus.access & ~halt_q;
  assign rd       = cpu_ok & bus.load;
  assign wr       = cpu_ok & ~bus.load;
  assign in_push  = bus.in_valid & bus.in_ready;
  assign in_pop   = rd & hit_in & ~in_empty;
  assign out_push = wr & hit_out & ~out_full;
  assign out_pop  = bus.out_valid & bus.out_ready;
  assign halt_set = (cpu_ok & hit_halt) | (rd & hit_in & in_empty & eof_q);

  // Stall depends only on registered occupancy, never on same-cycle stream handshakes.
  assign bus.stall     = (rd & hit_in & in_empty & ~eof_q) | (wr & hit_out & out_full);
  assign bus.in_ready  = rst_n & ~in_full;
  assign bus.out_valid = ~out_empty;
  assign bus.out_data  = out_mem[out_rd_q];
  assign bus.halt      = halt_q;
  assign bus.mem_we    = bus.access & ~bus.load & ~halt_q & ~hit_io;
  assign bus.mem_in    = hit_io ? '0 : bus.data_out;
  assign bus.addr_out  = bus.addr;

  always_comb begin
    bus.data_in = '0;
    if (!hit_io)
      bus.data_in = bus.mem_out;
    else if (bus.load && hit_in && !in_empty)
      bus.data_in = in_mem[in_rd_q];
`ifdef MMIO_STATUS_REG_EN
    else if (bus.load && hit_stat)
      bus.data_in = status_word;
`endif
  end

  always_comb begin
    in_wr_d   = in_push  ? in_wr_q  + IAW'(1) : in_wr_q;
    in_rd_d   = in_pop   ? in_rd_q  + IAW'(1) : in_rd_q;
    in_cnt_d  = in_cnt_q + (IAW+1)'(in_push) - (IAW+1)'(in_pop);
    out_wr_d  = out_push ? out_wr_q + OAW'(1) : out_wr_q;
    out_rd_d  = out_pop  ? out_rd_q + OAW'(1) : out_rd_q;
    out_cnt_d = out_cnt_q + (OAW+1)'(out_push) - (OAW+1)'(out_pop);
    halt_d    = halt_q | halt_set;
    eof_d     = eof_q | bus.in_eof;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
      halt_q    <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
      halt_q    <= halt_d;
      eof_q     <= eof_d;
    end
  end

  // Storage is not reset; occupancy counters define which entries are valid.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_q]   <= bus.in_data;
    if (out_push) out_mem[out_wr_q] <= bus.data_out;
  end
endmodule

// File: tb/tb_mmio_stream.sv
// Scoreboard bench for mmio_stream: stimulus queues expected read/stream words, monitor checks them.
module tb_mmio_stream;
  localparam logic [15:0] A_HALT = 16'hFFFF;
  localparam logic [15:0] A_IN   = 16'hFFFE;
  localparam logic [15:0] A_OUT  = 16'hFFFD;
  localparam logic [15:0] A_STAT = 16'hFFFC;
  localparam logic [15:0] MEMVAL = 16'hBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] cpu_q[$];
  logic [15:0] out_q[$];
  logic [15:0] mon_e, out_e;

  mmio_stream_if #(.WIDTH(16)) bus();
  mmio_stream #(.WIDTH(16), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.access && bus.load && !bus.stall) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_read_unexpected addr=%h: got %h expected none", bus.addr, bus.data_in);
      end else begin
        mon_e = cpu_q.pop_front();
        if (bus.data_in !== mon_e) begin
          errors++;
          $display("FAIL cpu_read addr=%h: got %h expected %h", bus.addr, bus.data_in, mon_e);
        end else
          $display("read  addr=%h data=%h", bus.addr, bus.data_in);
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h expected none", bus.out_data);
      end else begin
        out_e = out_q.pop_front();
        if (bus.out_data !== out_e) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", bus.out_data, out_e);
        end else
          $display("out   data=%h", bus.out_data);
      end
    end
  end

  task automatic push_in(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    $display("push  in=%h", d);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [15:0] exp, input bit nostall);
    int n;
    bus.access = 1'b1;
    bus.load   = 1'b1;
    bus.addr   = a;
    cpu_q.push_back(exp);
    n = 0;
    @(negedge clk);
    if (nostall) check("read_nostall", 32'(bus.stall), 32'd0);
    while (bus.stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (bus.stall) begin
      checks++;
      errors++;
      $display("FAIL read_timeout addr=%h: got stall=1 expected 0", a);
      cpu_q.delete(cpu_q.size() - 1);
    end
    @(posedge clk); #1;
    bus.access = 1'b0;
    bus.load   = 1'b0;
  endtask

  task automatic write_probe(input string name, input logic [15:0] a, input logic [15:0] d,
                             input logic exp_we, input logic [15:0] exp_min, input logic exp_stall);
    bus.access   = 1'b1;
    bus.load     = 1'b0;
    bus.addr     = a;
    bus.data_out = d;
    @(negedge clk);
    check({name, "_mem_we"}, 32'(bus.mem_we), 32'(exp_we));
    check({name, "_mem_in"}, 32'(bus.mem_in), 32'(exp_min));
    check({name, "_stall"}, 32'(bus.stall), 32'(exp_stall));
    @(posedge clk); #1;
    bus.access = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  initial begin
    bus.access = 0; bus.load = 0; bus.addr = 0; bus.data_out = 0; bus.mem_out = MEMVAL;
    bus.in_valid = 0; bus.in_data = 0; bus.in_eof = 0; bus.out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_halt", 32'(bus.halt), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain memory traffic
    cpu_read(16'h0100, MEMVAL, 1'b1);
    write_probe("memwr", 16'h0123, 16'h5555, 1'b1, 16'h5555, 1'b0);
`ifdef MMIO_STATUS_REG_EN
    cpu_read(A_STAT, 16'h0002, 1'b1);
    write_probe("statwr", A_STAT, 16'h1234, 1'b0, 16'h0000, 1'b0);
`else
    cpu_read(A_STAT, MEMVAL, 1'b1);
    write_probe("fffcwr", A_STAT, 16'h1234, 1'b1, 16'h1234, 1'b0);
`endif

    // Input FIFO first-word fall-through
    push_in(16'h0011);
    push_in(16'h0022);
    cpu_read(A_IN, 16'h0011, 1'b1);
    cpu_read(A_IN, 16'h0022, 1'b1);

    // Empty input stalls even when a push lands in the same cycle
    bus.access = 1'b1; bus.load = 1'b1; bus.addr = A_IN;
    bus.in_valid = 1'b1; bus.in_data = 16'h00AB;
    cpu_q.push_back(16'h00AB);
    @(negedge clk);
    check("empty_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("after_push_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    bus.access = 1'b0; bus.load = 1'b0;

    // Wrong-direction accesses are inert
    write_probe("wr_in", A_IN, 16'h7777, 1'b0, 16'h0000, 1'b0);
    cpu_read(A_OUT, 16'h0000, 1'b1);

    // Output FIFO fills, stalls, then drains in order
    for (int i = 1; i <= 4; i++) begin
      out_q.push_back(16'(i));
      write_probe("outwr", A_OUT, 16'(i), 1'b0, 16'h0000, 1'b0);
    end
    bus.access = 1'b1; bus.load = 1'b0; bus.addr = A_OUT; bus.data_out = 16'h0005;
    out_q.push_back(16'h0005);
    @(negedge clk);
    check("full_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_stall_pop_same_cycle", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_unstall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    bus.access = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("out_drained", 32'(bus.out_valid), 32'd0);

    // Reset mid-burst with words buffered and halt set
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_probe("burst_out", A_OUT, 16'hA1 + 16'(i), 1'b0, 16'h0000, 1'b0);
      push_in(16'hB1 + 16'(i));
    end
    write_probe("halt_wr", A_HALT, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("halt_by_addr", 32'(bus.halt), 32'd1);
    check("burst_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_halt", 32'(bus.halt), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.access = 1'b1; bus.load = 1'b1; bus.addr = A_IN;
    @(negedge clk);
    check("postrst_in_stall", 32'(bus.stall), 32'd1);
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.access = 1'b0; bus.load = 1'b0;

    // End of input: drain last word, next read halts
    bus.in_eof = 1'b1;
    push_in(16'h0007);
    cpu_read(A_IN, 16'h0007, 1'b1);
    check("eof_halt_pre", 32'(bus.halt), 32'd0);
    cpu_read(A_IN, 16'h0000, 1'b1);
    check("eof_halt", 32'(bus.halt), 32'd1);
    write_probe("halted_memwr", 16'h0200, 16'h4444, 1'b0, 16'h4444, 1'b0);
    bus.out_ready = 1'b0;
    write_probe("halted_outwr", A_OUT, 16'h0099, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("halted_no_push", 32'(bus.out_valid), 32'd0);
    check("halt_sticky", 32'(bus.halt), 32'd1);

    check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("out_q_empty", 32'(out_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
